wash_phase_timer: RTL and testbench
===================================

// Module: wash_phase_timer
// PURPOSE
//  Timing stage directly upstream of the washing-machine controller FSM. It times
//  the wash-cycle and spin phases and returns the cycle_timeout and spin_timeout
//  inputs the controller consumes. It infers the active phase from the controller's
//  motor_on, drain_valve_on and door_lock outputs, plus the drained level sensor.
// PARAMETERS
//  TICK_DIV   50_000_000  clocks per 1-second tick (>=1)
//  WASH_SECS  600         wash-cycle duration in ticks (0 allowed)
//  SPIN_SECS  300         spin duration in ticks (0 allowed)
//  CNT_W      16          width of second counter / secs_remaining; must hold max(WASH_SECS,SPIN_SECS)
// PORTS
//  clk             in   1      system clock, rising edge
//  reset           in   1      asynchronous, active-high reset
//  motor_on        in   1      from controller; high = wash cycle running
//  drain_valve_on  in   1      from controller; high in drain and spin
//  drained         in   1      level sensor; spin = drain_valve_on & drained
//  door_lock       in   1      from controller; low aborts any timing
//  cycle_timeout   out  1      registered level; wash duration elapsed
//  spin_timeout    out  1      registered level; spin duration elapsed
//  secs_remaining  out  CNT_W  ticks left in the active phase; 0 when idle
//  timer_busy      out  1      high in WASH or SPIN
// BEHAVIOUR
//  Reset: state=IDLE; pre_cnt=0; sec_cnt=0. All outputs 0. Reset mid-phase drops
//   timeouts immediately; counts do not resume.
//  run_wash = motor_on & door_lock.
//  run_spin = drain_valve_on & drained & door_lock & ~motor_on. Wash has priority.
//  States: IDLE, WASH, WASH_DONE, SPIN, SPIN_DONE. All outputs are registered.
//  IDLE:
//   - run_wash -> WASH. Load sec_cnt=WASH_SECS, pre_cnt=0.
//   - Else run_spin -> SPIN. Load sec_cnt=SPIN_SECS, pre_cnt=0.
//  WASH/SPIN:
//   - Each clock, pre_cnt++. When pre_cnt==TICK_DIV-1: tick, pre_cnt<=0, sec_cnt--.
//   - Tick with sec_cnt==1 -> *_DONE and assert the matching timeout.
//   - Loaded value 0 -> *_DONE on the first clock after entry.
//   - Timeout rises exactly DUR*TICK_DIV clocks after the entry edge
//     (1 clock if DUR=0).
//  *_DONE: timeout held high while the run condition holds.
//   - Run condition low -> IDLE, timeout cleared on that edge.
//   - Normal handshake: controller drops motor_on combinationally on timeout, so the
//     timeout is high for exactly 1 clock.
//  Abort: run condition falls in WASH/SPIN before completion ->
//   - IDLE, counters cleared, no timeout pulse.
//   - Re-entry restarts the full duration; there is no pause/resume.
//  Phase switch: a direct run_wash <-> run_spin change in any non-IDLE state goes via
//   IDLE (1 clock), then starts the new phase.
//  secs_remaining = sec_cnt in WASH/SPIN, 0 otherwise. timer_busy = (WASH|SPIN).
//  cycle_timeout and spin_timeout are never high together.
//  Counters saturate at 0; sec_cnt never wraps.
// TESTING (TICK_DIV=4, WASH_SECS=3, SPIN_SECS=2, CNT_W=4)
//  1) Reset 3 clk, release; motor_on=1 held -> busy=1, secs_remaining 3,2,1 every 4
//     clk; cycle_timeout=1 on clk 12 after entry.
//  2) Drop motor_on 1 clk after cycle_timeout -> cycle_timeout=0 next edge, state
//     IDLE, secs_remaining=0.
//  3) drain_valve_on=1, drained=0 for 20 clk -> no activity. Then drained=1 ->
//     spin_timeout=1 exactly 8 clk after SPIN entry.
//  4) motor_on=1; door_lock falls after 5 clk -> busy=0 next edge, no timeout.
//     Relock -> full 12 clk again.
//  5) WASH_SECS=0 variant: motor_on=1 -> cycle_timeout=1 one clk after WASH entry.
//  6) Assert reset in SPIN with 1 tick left -> all outputs 0 at once; spin_timeout
//     never pulses.

Source files
------------

// File: rtl/wash_phase_timer.sv
// Wash/spin phase timer feeding cycle_timeout and spin_timeout to the washer controller.
// Phase is inferred from the controller outputs; all outputs are registered.
module wash_phase_timer #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned WASH_SECS = 600,
  parameter int unsigned SPIN_SECS = 300,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motor_on,
  input  logic             drain_valve_on,
  input  logic             drained,
  input  logic             door_lock,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic [CNT_W-1:0] secs_remaining,
  output logic             timer_busy
);

  localparam int unsigned      PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] WASH_LOAD = CNT_W'(WASH_SECS);
  localparam logic [CNT_W-1:0] SPIN_LOAD = CNT_W'(SPIN_SECS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WASH      = 3'd1,
    WASH_DONE = 3'd2,
    SPIN      = 3'd3,
    SPIN_DONE = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;
  logic [CNT_W-1:0] sec_cnt_reg, sec_cnt_next;

  logic run_wash;
  logic run_spin;
  logic run_active;
  logic tick;
  logic in_wash_phase;
  logic timing_next;

  assign run_wash = motor_on & door_lock;
  assign run_spin = drain_valve_on & drained & door_lock & ~motor_on;
  assign tick     = (pre_cnt_reg == PRE_MAX);

  // Run condition of whichever phase we are currently in; a switch to the other
  // phase makes this fall, so phase changes always pass through IDLE.
  assign in_wash_phase = (state_reg == WASH) || (state_reg == WASH_DONE);
  assign run_active    = in_wash_phase ? run_wash : run_spin;

  always_comb begin
    state_next   = state_reg;
    pre_cnt_next = pre_cnt_reg;
    sec_cnt_next = sec_cnt_reg;

    case (state_reg)
      IDLE: begin
        pre_cnt_next = '0;
        sec_cnt_next = '0;
        if (run_wash) begin
          state_next   = WASH;
          sec_cnt_next = WASH_LOAD;
        end else if (run_spin) begin
          state_next   = SPIN;
          sec_cnt_next = SPIN_LOAD;
        end
      end

      WASH, SPIN: begin
        if (!run_active) begin
          state_next   = IDLE;
          pre_cnt_next = '0;
          sec_cnt_next = '0;
        end else if (sec_cnt_reg == '0) begin
          // Zero-length phase completes on the first clock after entry.
          state_next   = (state_reg == WASH) ? WASH_DONE : SPIN_DONE;
          pre_cnt_next = '0;
        end else if (tick) begin
          pre_cnt_next = '0;
          if (sec_cnt_reg == CNT_ONE) begin
            state_next   = (state_reg == WASH) ? WASH_DONE : SPIN_DONE;
            sec_cnt_next = '0;
          end else begin
            sec_cnt_next = sec_cnt_reg - CNT_ONE;
          end
        end else begin
          pre_cnt_next = pre_cnt_reg + PRE_W'(1);
        end
      end

      WASH_DONE, SPIN_DONE: begin
        pre_cnt_next = '0;
        sec_cnt_next = '0;
        if (!run_active) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next   = IDLE;
        pre_cnt_next = '0;
        sec_cnt_next = '0;
      end
    endcase
  end

  assign timing_next = (state_next == WASH) || (state_next == SPIN);

  // Outputs are derived from next-state values so they register in step with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pre_cnt_reg    <= '0;
      sec_cnt_reg    <= '0;
      cycle_timeout  <= 1'b0;
      spin_timeout   <= 1'b0;
      secs_remaining <= '0;
      timer_busy     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pre_cnt_reg    <= pre_cnt_next;
      sec_cnt_reg    <= sec_cnt_next;
      cycle_timeout  <= (state_next == WASH_DONE);
      spin_timeout   <= (state_next == SPIN_DONE);
      secs_remaining <= timing_next ? sec_cnt_next : '0;
      timer_busy     <= timing_next;
    end
  end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer: one task per scenario, checks packed
// {busy, cycle_timeout, spin_timeout, secs_remaining} against hand-computed values.
module tb_wash_phase_timer;

  logic       clk;
  logic       reset;
  logic       motor_on;
  logic       drain_valve_on;
  logic       drained;
  logic       door_lock;

  logic       cycle_timeout, spin_timeout, timer_busy;
  logic [3:0] secs_remaining;
  logic       z_cycle_timeout, z_spin_timeout, z_timer_busy;
  logic [3:0] z_secs_remaining;

  int checks;
  int errors;

  logic [6:0] o;
  logic [6:0] oz;
  logic [6:0] exp_o;

  assign o  = {timer_busy, cycle_timeout, spin_timeout, secs_remaining};
  assign oz = {z_timer_busy, z_cycle_timeout, z_spin_timeout, z_secs_remaining};

  wash_phase_timer #(.TICK_DIV(4), .WASH_SECS(3), .SPIN_SECS(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .motor_on(motor_on), .drain_valve_on(drain_valve_on),
    .drained(drained), .door_lock(door_lock), .cycle_timeout(cycle_timeout),
    .spin_timeout(spin_timeout), .secs_remaining(secs_remaining), .timer_busy(timer_busy)
  );

  wash_phase_timer #(.TICK_DIV(4), .WASH_SECS(0), .SPIN_SECS(2), .CNT_W(4)) dut_z (
    .clk(clk), .reset(reset), .motor_on(motor_on), .drain_valve_on(drain_valve_on),
    .drained(drained), .door_lock(door_lock), .cycle_timeout(z_cycle_timeout),
    .spin_timeout(z_spin_timeout), .secs_remaining(z_secs_remaining), .timer_busy(z_timer_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output vector for the wash phase k clocks after the entry edge.
  function automatic logic [6:0] wash_exp(input int k);
    if (k >= 12) return {1'b0, 1'b1, 1'b0, 4'd0};
    if (k < 4)   return {1'b1, 1'b0, 1'b0, 4'd3};
    if (k < 8)   return {1'b1, 1'b0, 1'b0, 4'd2};
    return {1'b1, 1'b0, 1'b0, 4'd1};
  endfunction

  task automatic test_reset();
    reset = 1'b1; motor_on = 1'b0; drain_valve_on = 1'b0; drained = 1'b0; door_lock = 1'b1;
    repeat (3) step();
    checks++;
    if (o !== 7'd0) begin errors++; $display("FAIL reset_held got %b exp %b", o, 7'd0); end
    checks++;
    if (oz !== 7'd0) begin errors++; $display("FAIL reset_held_z got %b exp %b", oz, 7'd0); end
    reset = 1'b0;
    step();
    checks++;
    if (o !== 7'd0) begin errors++; $display("FAIL reset_release got %b exp %b", o, 7'd0); end
  endtask

  task automatic test_wash();
    motor_on = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      exp_o = wash_exp(k);
      checks++;
      if (o !== exp_o) begin errors++; $display("FAIL wash_k%0d got %b exp %b", k, o, exp_o); end
    end
    step();
    checks++;
    if (o !== 7'b0100000) begin errors++; $display("FAIL wash_hold got %b exp %b", o, 7'b0100000); end
    motor_on = 1'b0;
    step();
    checks++;
    if (o !== 7'd0) begin errors++; $display("FAIL wash_release got %b exp %b", o, 7'd0); end
  endtask

  task automatic test_spin_gate();
    drain_valve_on = 1'b1; drained = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (o !== 7'd0) begin errors++; $display("FAIL spin_gate_k%0d got %b exp %b", k, o, 7'd0); end
    end
    drained = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      if (k == 8)     exp_o = {1'b0, 1'b0, 1'b1, 4'd0};
      else if (k < 4) exp_o = {1'b1, 1'b0, 1'b0, 4'd2};
      else            exp_o = {1'b1, 1'b0, 1'b0, 4'd1};
      checks++;
      if (o !== exp_o) begin errors++; $display("FAIL spin_k%0d got %b exp %b", k, o, exp_o); end
    end
    drain_valve_on = 1'b0;
    step();
    checks++;
    if (o !== 7'd0) begin errors++; $display("FAIL spin_release got %b exp %b", o, 7'd0); end
    drained = 1'b0;
  endtask

  task automatic test_abort();
    motor_on = 1'b1;
    step();
    repeat (5) step();
    checks++;
    if (o !== 7'b1000010) begin errors++; $display("FAIL abort_pre got %b exp %b", o, 7'b1000010); end
    door_lock = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (o !== 7'd0) begin errors++; $display("FAIL abort_idle_k%0d got %b exp %b", k, o, 7'd0); end
    end
    door_lock = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      exp_o = wash_exp(k);
      checks++;
      if (o !== exp_o) begin errors++; $display("FAIL relock_k%0d got %b exp %b", k, o, exp_o); end
    end
    motor_on = 1'b0;
    step();
    checks++;
    if (o !== 7'd0) begin errors++; $display("FAIL relock_release got %b exp %b", o, 7'd0); end
  endtask

  task automatic test_phase_switch();
    motor_on = 1'b1;
    step();
    step();
    motor_on = 1'b0; drain_valve_on = 1'b1; drained = 1'b1;
    step();
    checks++;
    if (o !== 7'd0) begin errors++; $display("FAIL switch_idle got %b exp %b", o, 7'd0); end
    step();
    checks++;
    if (o !== 7'b1000010) begin errors++; $display("FAIL switch_spin got %b exp %b", o, 7'b1000010); end
    drain_valve_on = 1'b0; drained = 1'b0;
    step();
    checks++;
    if (o !== 7'd0) begin errors++; $display("FAIL switch_release got %b exp %b", o, 7'd0); end
  endtask

  task automatic test_zero_wash();
    motor_on = 1'b1;
    step();
    checks++;
    if (oz !== 7'b1000000) begin errors++; $display("FAIL zero_entry got %b exp %b", oz, 7'b1000000); end
    step();
    checks++;
    if (oz !== 7'b0100000) begin errors++; $display("FAIL zero_timeout got %b exp %b", oz, 7'b0100000); end
    motor_on = 1'b0;
    step();
    checks++;
    if (oz !== 7'd0) begin errors++; $display("FAIL zero_release got %b exp %b", oz, 7'd0); end
  endtask

  task automatic test_reset_in_spin();
    drain_valve_on = 1'b1; drained = 1'b1;
    step();
    repeat (6) step();
    checks++;
    if (o !== 7'b1000001) begin errors++; $display("FAIL rst_spin_pre got %b exp %b", o, 7'b1000001); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (o !== 7'd0) begin errors++; $display("FAIL rst_spin_async got %b exp %b", o, 7'd0); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (o !== 7'd0) begin errors++; $display("FAIL rst_spin_held_k%0d got %b exp %b", k, o, 7'd0); end
    end
    drain_valve_on = 1'b0; drained = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (o !== 7'd0) begin errors++; $display("FAIL rst_spin_after_k%0d got %b exp %b", k, o, 7'd0); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_wash();
    test_spin_gate();
    test_abort();
    test_phase_switch();
    test_zero_wash();
    test_reset_in_spin();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
